// File: rtl/serial_adder_seq.sv
// Bit-serial adder: two cascaded half adders and a carry flop process one operand
// bit per clock, LSB first. The result is presented in parallel together with a done pulse.
module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry
);
    // state | meaning
    // IDLE  | waiting for start
    // RUN   | one operand bit added per cycle, LSB first
    // DONE  | Sum/Carry freshly updated; start here chains the next add
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // half adder cell: {carry, sum}
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    logic [1:0]       state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             carry_ff;
    logic [1:0]       ha0;
    logic [1:0]       ha1;
    logic             cn;

    assign ha0 = half_add(opa[0], opb[0]);
    assign ha1 = half_add(ha0[0], carry_ff);
    assign cn  = ha0[1] | ha1[1];

    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_next = ha1[0];
        end else begin : g_res_wn
            assign res_next = {ha1[0], res[WIDTH-1:1]};
        end
    endgenerate

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            opa      <= '0;
            opb      <= '0;
            res      <= '0;
            cnt      <= '0;
            carry_ff <= 1'b0;
            Sum      <= '0;
            Carry    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        opa      <= A;
                        opb      <= B;
                        res      <= '0;
                        cnt      <= '0;
                        carry_ff <= 1'b0;
                        state    <= RUN;
                    end else begin
                        state    <= IDLE;
                    end
                end
                RUN: begin
                    opa      <= opa >> 1;
                    opb      <= opb >> 1;
                    res      <= res_next;
                    carry_ff <= cn;
                    cnt      <= cnt + CW'(1);
                    // Capture on the last bit so Sum/Carry are valid while done is high.
                    if (cnt == LAST) begin
                        Sum   <= res_next;
                        Carry <= cn;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_seq.sv
// Scoreboard bench for serial_adder_seq at WIDTH=8 and WIDTH=4: expected sums are
// queued when an add is launched and are compared when done pulses.
module tb_serial_adder_seq;
    logic       clk = 1'b0;
    logic       rst;
    logic       start8, start4;
    logic [7:0] a8, b8, sum8;
    logic [3:0] a4, b4, sum4;
    logic       busy8, done8, carry8;
    logic       busy4, done4, carry4;

    logic [8:0] q8[$];
    logic [4:0] q4[$];
    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_adder_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .Sum(sum8), .Carry(carry8)
    );

    serial_adder_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4),
        .busy(busy4), .done(done4), .Sum(sum4), .Carry(carry4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitors, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy_done_excl8", 32'(busy8 & done8), 32'd0);
            if (done8) begin
                chk("done8_expected", 32'(q8.size() != 0), 32'd1);
                if (q8.size() != 0) chk("result8", 32'({carry8, sum8}), 32'(q8.pop_front()));
            end
            if (done4) begin
                chk("done4_expected", 32'(q4.size() != 0), 32'd1);
                if (q4.size() != 0) chk("result4", 32'({carry4, sum4}), 32'(q4.pop_front()));
            end
        end
    end

    task automatic go8(input logic [7:0] a, input logic [7:0] b);
        int guard = 0;
        @(negedge clk);
        while (busy8 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        start8 = 1'b1; a8 = a; b8 = b;
        q8.push_back(9'(a) + 9'(b));
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic go4(input logic [3:0] a, input logic [3:0] b);
        int guard = 0;
        @(negedge clk);
        while (busy4 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        start4 = 1'b1; a4 = a; b4 = b;
        q4.push_back(5'(a) + 5'(b));
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while ((q8.size() != 0 || q4.size() != 0) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk(tag, 32'(q8.size() + q4.size()), 32'd0);
    endtask

    initial begin
        int k, nbusy, k1;
        rst = 1'b1; start8 = 1'b0; start4 = 1'b0;
        a8 = '0; b8 = '0; a4 = '0; b4 = '0;

        // reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_sum",  32'(sum8), 32'd0);
        chk("rst_carry", 32'(carry8), 32'd0);
        chk("rst_busy4", 32'(busy4), 32'd0);

        // FF + 01: latency and busy length
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; q8.push_back(9'h100);
        @(negedge clk);
        start8 = 1'b0;
        k = 1; nbusy = 0;
        while (!done8 && k < 20) begin
            if (busy8) nbusy++;
            @(negedge clk);
            k++;
        end
        chk("latency", 32'(k), 32'd9);
        chk("busy_cycles", 32'(nbusy), 32'd8);
        repeat (3) @(negedge clk);
        chk("sum_hold", 32'({carry8, sum8}), 32'h100);
        chk("idle_after_done", 32'(busy8 | done8), 32'd0);

        // 5A + A5 with a start pulse mid-run that must be ignored
        start8 = 1'b1; a8 = 8'h5A; b8 = 8'hA5; q8.push_back(9'h0FF);
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
        @(negedge clk);
        start8 = 1'b0;
        repeat (15) @(negedge clk);
        chk("midrun_start_result", 32'({carry8, sum8}), 32'h0FF);
        chk("midrun_start_idle", 32'(busy8), 32'd0);

        // reset on the 4th RUN cycle abandons the add
        start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; q8.push_back(9'h100);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        q8.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_done", 32'(done8), 32'd0);
        chk("abort_result", 32'({carry8, sum8}), 32'd0);
        repeat (12) @(negedge clk);
        chk("abort_no_done_result", 32'({carry8, sum8}), 32'd0);

        // back-to-back with start held through DONE
        start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; q8.push_back(9'h100);
        @(negedge clk);
        a8 = 8'h0F; b8 = 8'h01; q8.push_back(9'h010);
        k = 1;
        while (!done8 && k < 20) begin
            @(negedge clk);
            k++;
        end
        k1 = k;
        @(negedge clk);
        start8 = 1'b0;
        k++;
        while (!done8 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("b2b_spacing", 32'(k - k1), 32'd9);
        chk("b2b_second", 32'({carry8, sum8}), 32'h010);
        @(negedge clk);
        chk("b2b_idle", 32'(busy8 | done8), 32'd0);

        // boundary operands and random pairs at WIDTH=8
        go8(8'h00, 8'h00);
        go8(8'hFF, 8'hFF);
        go8(8'h7F, 8'h01);
        for (int i = 0; i < 1000; i++) go8(8'($urandom), 8'($urandom));
        drain("drain8");

        // exhaustive at WIDTH=4
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                go4(4'(a), 4'(b));
        drain("drain4");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
